decoder_pipe: RTL and testbench
===============================

DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL provide parameter M, default 4, width of the encoded input (M >= 1).
REQ-002 SHALL provide parameter N, default 2**M, number of output bits (1 <= N <= 2**M).
REQ-003 SHALL provide parameter MODE, default 0, output mode: 0 = one-hot, 1 = thermometer.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named i_clk and i_rst.
REQ-005 i_clk  input  1  clock; all state updates on the rising edge.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_valid  input  1  upstream: i_encoded is valid.
REQ-008 i_encoded  input  M  upstream: code to decode.
REQ-009 o_ready  output  1  upstream: block can accept a code.
REQ-010 o_valid  output  1  downstream: o_data and o_err are valid.
REQ-011 o_data  output  N  downstream: decoded pattern.
REQ-012 o_err  output  1  downstream: the code was out of range (i_encoded >= N).
REQ-013 i_ready  input  1  downstream: consumer accepts this cycle.

Function
REQ-014 Upstream transfer SHALL occur on a cycle with i_valid && o_ready; downstream transfer SHALL occur on a cycle with o_valid && i_ready.
REQ-015 Decode, one-hot mode: o_data[j] = (code == j) for j in 0..N-1.
REQ-016 Decode, thermometer mode: o_data[j] = (j <= code) for j in 0..N-1.
REQ-017 An out-of-range code (code >= N, possible only when N < 2**M) SHALL produce o_data = 0 and o_err = 1 in both modes; an in-range code SHALL produce o_err = 0.
REQ-018 Decoding SHALL take place at upstream transfer; the result is registered, so latency from upstream transfer to o_valid is exactly 1 cycle.
REQ-019 Storage SHALL be an output register (OUT) plus one skid register (SKID), 2 entries total, with states EMPTY (0 held), ONE (OUT valid), FULL (OUT and SKID valid).
REQ-020 o_ready SHALL be a registered signal equal to !SKID.valid; it SHALL be low only in FULL.
REQ-021 EMPTY: an upstream transfer loads OUT and goes to ONE.
REQ-022 ONE with downstream transfer: a simultaneous upstream transfer reloads OUT and stays in ONE; without one, go to EMPTY.
REQ-023 ONE without downstream transfer: an upstream transfer loads SKID and goes to FULL.
REQ-024 FULL with downstream transfer: SKID moves to OUT and the state goes to ONE; no upstream transfer can occur, because o_ready = 0.
REQ-025 FULL without downstream transfer: hold all state.
REQ-026 With i_ready held high, the block SHALL sustain 1 transfer per cycle with no bubbles.
REQ-027 While o_valid && !i_ready, o_data and o_err SHALL remain stable.
REQ-028 Ordering SHALL be FIFO; no code is dropped or duplicated.
REQ-029 i_encoded is ignored when i_valid = 0 or o_ready = 0.

Reset
REQ-030 Asserting i_rst SHALL immediately force: o_valid = 0, o_data = 0, o_err = 0, SKID empty, state EMPTY.
REQ-031 o_ready SHALL read 1 during reset and on the first cycle after release.
REQ-032 Reset asserted mid-operation SHALL discard any held data; no stale transfer appears after release.

Verification
REQ-033 M=3, N=8, MODE=0, i_ready=1: send codes 0..7 back to back -> o_data = 0x01, 0x02, ... 0x80 on consecutive cycles, each one cycle after input; o_err = 0 throughout.
REQ-034 M=3, N=6, MODE=0: send code 6, then code 7 -> each gives o_data = 0x00 and o_err = 1; code 5 -> o_data = 0x20, o_err = 0.
REQ-035 M=3, N=8, MODE=1: send codes 0, 3, 7 -> o_data = 0x01, 0x0F, 0xFF.
REQ-036 Backpressure: i_ready = 0, send codes 2 and 4 -> o_valid = 1 with o_data = 0x04 held stable; o_ready = 0 after the 2nd accept. Raise i_ready -> 0x04 then 0x10 are delivered in order, and o_ready returns to 1.
REQ-037 Random i_valid/i_ready at 50% for 10k cycles, compared against a reference queue -> no loss, duplication or reordering; protocol stability rules hold.
REQ-038 Assert i_rst while FULL -> o_valid = 0 in the same cycle; after release o_ready = 1 and no output appears until a new transfer.

Source files
------------

// File: rtl/decoder_pipe_if.sv
// Upstream code handshake plus downstream decoded-pattern handshake for decoder_pipe.
interface decoder_pipe_if #(
  parameter int M = 4,
  parameter int N = 2**M
);
  logic         i_valid;
  logic [M-1:0] i_encoded;
  logic         o_ready;
  logic         o_valid;
  logic [N-1:0] o_data;
  logic         o_err;
  logic         i_ready;

  modport slave (
    input  i_valid, i_encoded, i_ready,
    output o_ready, o_valid, o_data, o_err
  );

  modport master (
    output i_valid, i_encoded, i_ready,
    input  o_ready, o_valid, o_data, o_err
  );
endinterface

// File: rtl/decoder_pipe.sv
// One-hot/thermometer decoder with out-of-range flag; 1-cycle latency, 2-entry (OUT+SKID) buffer,
// full throughput; registered o_ready drops only when both entries are held.
module decoder_pipe #(
  parameter int M    = 4,
  parameter int N    = 2**M,
  parameter int MODE = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  decoder_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Result packed as {err, pattern}; out-of-range codes decode to an all-zero pattern.
  function automatic logic [N:0] decode(input logic [M-1:0] code);
    logic [N-1:0] pat;
    logic         err;
    pat = '0;
    err = (int'(code) >= N);
    for (int j = 0; j < N; j++) begin
      if (MODE == 0) pat[j] = (int'(code) == j);
      else           pat[j] = (j <= int'(code));
    end
    if (err) pat = '0;
    return {err, pat};
  endfunction

  state_t       state, state_n;
  logic [N-1:0] out_data, skid_data;
  logic         out_err, skid_err;
  logic         ready_q, ready_n;
  logic [N:0]   dec;
  logic         up_xfer, dn_xfer;
  logic         load_out, load_out_skid, load_skid;

  assign dec     = decode(bus.i_encoded);
  assign up_xfer = bus.i_valid && ready_q;
  assign dn_xfer = (state != EMPTY) && bus.i_ready;

  always_comb begin
    state_n       = state;
    load_out      = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (up_xfer) begin
          load_out = 1'b1;
          state_n  = ONE;
        end
      end
      ONE: begin
        if (dn_xfer) begin
          if (up_xfer) load_out = 1'b1;
          else         state_n  = EMPTY;
        end else if (up_xfer) begin
          load_skid = 1'b1;
          state_n   = FULL;
        end
      end
      FULL: begin
        // o_ready is low here, so no new code can arrive alongside the drain.
        if (dn_xfer) begin
          load_out_skid = 1'b1;
          state_n       = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    ready_n = (state_n != FULL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= EMPTY;
      ready_q   <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= ready_n;
      if (load_out) begin
        out_data <= dec[N-1:0];
        out_err  <= dec[N];
      end else if (load_out_skid) begin
        out_data <= skid_data;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= dec[N-1:0];
        skid_err  <= dec[N];
      end
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = (state != EMPTY);
  assign bus.o_data  = out_data;
  assign bus.o_err   = out_err;

endmodule

// File: tb/tb_decoder_pipe.sv
// Three decoder_pipe configurations checked against a queue-based reference model plus directed literals.
module tb_decoder_pipe;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  decoder_pipe_if #(.M(3), .N(8)) if0 ();
  decoder_pipe_if #(.M(3), .N(6)) if1 ();
  decoder_pipe_if #(.M(3), .N(8)) if2 ();

  decoder_pipe #(.M(3), .N(8), .MODE(0)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
  decoder_pipe #(.M(3), .N(6), .MODE(0)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
  decoder_pipe #(.M(3), .N(8), .MODE(1)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));

  logic       iv [3];
  logic [2:0] ie [3];
  logic       ir [3];
  logic       ov [3];
  logic       ordy [3];
  logic       oe [3];
  logic [7:0] od [3];

  assign if0.i_valid = iv[0]; assign if0.i_encoded = ie[0]; assign if0.i_ready = ir[0];
  assign if1.i_valid = iv[1]; assign if1.i_encoded = ie[1]; assign if1.i_ready = ir[1];
  assign if2.i_valid = iv[2]; assign if2.i_encoded = ie[2]; assign if2.i_ready = ir[2];

  assign ov[0] = if0.o_valid; assign ordy[0] = if0.o_ready; assign oe[0] = if0.o_err; assign od[0] = if0.o_data;
  assign ov[1] = if1.o_valid; assign ordy[1] = if1.o_ready; assign oe[1] = if1.o_err; assign od[1] = {2'b00, if1.o_data};
  assign ov[2] = if2.o_valid; assign ordy[2] = if2.o_ready; assign oe[2] = if2.o_err; assign od[2] = if2.o_data;

  int         n_of    [3] = '{8, 6, 8};
  int         mode_of [3] = '{0, 0, 1};
  logic [8:0] mq [3][$];

  logic [7:0] lit_a [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [2:0] code_b [3] = '{3'd6, 3'd7, 3'd5};
  logic [8:0] lit_b  [3] = '{9'h100, 9'h100, 9'h020};
  logic [2:0] code_c [3] = '{3'd0, 3'd3, 3'd7};
  logic [7:0] lit_c  [3] = '{8'h01, 8'h0F, 8'hFF};

  // Expected {err, pattern} straight from the decode rules.
  function automatic logic [8:0] expect_code(input int code, input int n, input int mode);
    int pat;
    if (code >= n) return 9'h100;
    if (mode == 0) pat = 1 << code;
    else           pat = (1 << (code + 1)) - 1;
    return {1'b0, pat[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'd0);
        chk($sformatf("rst_data%0d", i), 32'(od[i]), 32'd0);
        chk($sformatf("rst_err%0d", i), 32'(oe[i]), 32'd0);
        chk($sformatf("rst_ready%0d", i), 32'(ordy[i]), 32'd1);
        mq[i].delete();
      end else begin
        logic room;
        room = (mq[i].size() < 2);
        chk($sformatf("ready%0d", i), 32'(ordy[i]), 32'(room));
        chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(mq[i].size() > 0));
        if (ov[i] && mq[i].size() > 0) begin
          chk($sformatf("data%0d", i), 32'(od[i]), 32'(mq[i][0][7:0]));
          chk($sformatf("err%0d", i), 32'(oe[i]), 32'(mq[i][0][8]));
        end
        if (ir[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (iv[i] && room) mq[i].push_back(expect_code(int'(ie[i]), n_of[i], mode_of[i]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ie[i] = 3'd0; ir[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // One-hot, full range, back to back
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      iv[0] = (k < 8);
      ie[0] = 3'(k);
      @(negedge clk);
      if (k > 0) begin
        chk("a_valid", 32'(ov[0]), 32'd1);
        chk("a_data", 32'(od[0]), 32'(lit_a[k-1]));
        chk("a_err", 32'(oe[0]), 32'd0);
      end
    end

    // Out-of-range codes with N=6
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      iv[1] = (k < 3);
      ie[1] = (k < 3) ? code_b[k] : 3'd0;
      @(negedge clk);
      if (k > 0) begin
        chk("b_valid", 32'(ov[1]), 32'd1);
        chk("b_data", 32'(od[1]), 32'(lit_b[k-1][7:0]));
        chk("b_err", 32'(oe[1]), 32'(lit_b[k-1][8]));
      end
    end

    // Thermometer mode
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      iv[2] = (k < 3);
      ie[2] = (k < 3) ? code_c[k] : 3'd0;
      @(negedge clk);
      if (k > 0) begin
        chk("c_valid", 32'(ov[2]), 32'd1);
        chk("c_data", 32'(od[2]), 32'(lit_c[k-1]));
        chk("c_err", 32'(oe[2]), 32'd0);
      end
    end

    // Backpressure: codes 2 and 4 held, then drained in order
    @(posedge clk); #1; ir[0] = 1'b0; iv[0] = 1'b1; ie[0] = 3'd2;
    @(posedge clk); #1; ie[0] = 3'd4;
    @(posedge clk); #1; iv[0] = 1'b0; ie[0] = 3'd7;
    repeat (2) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov[0]), 32'd1);
      chk("bp_data", 32'(od[0]), 32'h04);
      chk("bp_ready", 32'(ordy[0]), 32'd0);
    end
    @(posedge clk); #1; ir[0] = 1'b1;
    @(negedge clk);
    chk("bp_first", 32'(od[0]), 32'h04);
    @(negedge clk);
    chk("bp_second", 32'(od[0]), 32'h10);
    chk("bp_second_valid", 32'(ov[0]), 32'd1);
    chk("bp_ready_back", 32'(ordy[0]), 32'd1);
    @(negedge clk);
    chk("bp_drained", 32'(ov[0]), 32'd0);

    // Reset while FULL
    @(posedge clk); #1; ir[0] = 1'b0; iv[0] = 1'b1; ie[0] = 3'd1;
    @(posedge clk); #1; ie[0] = 3'd5;
    @(posedge clk); #1; iv[0] = 1'b0;
    @(negedge clk);
    chk("e_full_ready", 32'(ordy[0]), 32'd0);
    chk("e_full_valid", 32'(ov[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("e_rst_valid", 32'(ov[0]), 32'd0);
    chk("e_rst_ready", 32'(ordy[0]), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0; ir[0] = 1'b1;
    @(negedge clk);
    chk("e_post_ready", 32'(ordy[0]), 32'd1);
    chk("e_post_valid", 32'(ov[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("e_no_stale", 32'(ov[0]), 32'd0);
    end

    // Random traffic on all three configurations
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        iv[i] = 1'($urandom_range(0, 1));
        ie[i] = 3'($urandom_range(0, 7));
        ir[i] = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ir[i] = 1'b1;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("drain_valid%0d", i), 32'(ov[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
